// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: req/ack bus master with byte/half/word
// alignment, byte enables, load extension and upstream stall generation.
module mem_access_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic [1:0]  Size_in,
  input  logic        Unsigned_in,
  input  logic [31:0] ALUData_in,
  input  logic [31:0] StoreData_in,
  input  logic        RegWrite_in,
  input  logic        MemtoReg_in,
  input  logic [4:0]  WBregister_in,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        RegWrite_out,
  output logic        MemtoReg_out,
  output logic [31:0] MemData_out,
  output logic [31:0] ALUData_out,
  output logic [4:0]  WBregister_out,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  output logic        misalign,
  output logic        bus_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_q, state_d;
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [3:0]      be_q, be_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;

  logic [1:0]  a;
  logic        is_mem;
  logic        aligned;
  logic        access;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic [7:0]  byte_c;
  logic [15:0] half_c;

  assign a       = ALUData_in[1:0];
  assign is_mem  = MemRead_in | MemWrite_in;

  always_comb begin
    aligned = 1'b1;
    be_c    = 4'b1111;
    wdata_c = StoreData_in;
    unique case (Size_in)
      2'b00: begin
        be_c    = 4'b0001 << a;
        wdata_c = {4{StoreData_in[7:0]}};
      end
      2'b01: begin
        aligned = ~a[0];
        be_c    = a[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{StoreData_in[15:0]}};
      end
      default: aligned = (a == 2'b00);
    endcase
  end

  assign access   = is_mem & aligned;
  assign misalign = (state_q == IDLE) & is_mem & ~aligned;

  // Load extraction works on the latched word; EX/MEM is frozen by stall.
  always_comb begin
    byte_c = rdata_q[7:0];
    unique case (a)
      2'b00: byte_c = rdata_q[7:0];
      2'b01: byte_c = rdata_q[15:8];
      2'b10: byte_c = rdata_q[23:16];
      2'b11: byte_c = rdata_q[31:24];
    endcase
    half_c = a[1] ? rdata_q[31:16] : rdata_q[15:0];
    unique case (Size_in)
      2'b00:   MemData_out = {{24{byte_c[7] & ~Unsigned_in}}, byte_c};
      2'b01:   MemData_out = {{16{half_c[15] & ~Unsigned_in}}, half_c};
      default: MemData_out = rdata_q;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    rdata_d      = rdata_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    stall        = 1'b0;
    RegWrite_out = 1'b0;
    bus_err      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (access) begin
          stall   = 1'b1;
          req_d   = 1'b1;
          we_d    = MemWrite_in;
          addr_d  = {ALUData_in[31:2], 2'b00};
          wdata_d = wdata_c;
          be_d    = be_c;
          cnt_d   = '0;
          state_d = BUSY;
        end else begin
          RegWrite_out = RegWrite_in & ~misalign;
        end
      end
      BUSY: begin
        stall = 1'b1;
        cnt_d = cnt_q + CW'(1);
        if (mem_ack) begin
          if (!we_q) rdata_d = mem_rdata;
          req_d   = 1'b0;
          state_d = DONE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        RegWrite_out = RegWrite_in & ~err_q;
        bus_err      = err_q;
        err_d        = 1'b0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign MemtoReg_out   = MemtoReg_in;
  assign ALUData_out    = ALUData_in;
  assign WBregister_out = WBregister_in;
  assign mem_req        = req_q;
  assign mem_we         = we_q;
  assign mem_addr       = addr_q;
  assign mem_wdata      = wdata_q;
  assign mem_be         = be_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: loads, stores, misalign, timeout, reset.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemRead_in, MemWrite_in, Unsigned_in;
  logic [1:0]  Size_in;
  logic [31:0] ALUData_in, StoreData_in;
  logic        RegWrite_in, MemtoReg_in;
  logic [4:0]  WBregister_in;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        RegWrite_out, MemtoReg_out;
  logic [31:0] MemData_out, ALUData_out;
  logic [4:0]  WBregister_out;
  logic        stall, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        misalign, bus_err;

  int checks = 0;
  int errors = 0;
  int stall_cnt;
  int req_cnt;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
    .Size_in(Size_in), .Unsigned_in(Unsigned_in),
    .ALUData_in(ALUData_in), .StoreData_in(StoreData_in),
    .RegWrite_in(RegWrite_in), .MemtoReg_in(MemtoReg_in),
    .WBregister_in(WBregister_in),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .RegWrite_out(RegWrite_out), .MemtoReg_out(MemtoReg_out),
    .MemData_out(MemData_out), .ALUData_out(ALUData_out),
    .WBregister_out(WBregister_out),
    .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .misalign(misalign), .bus_err(bus_err)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic set_nop();
    MemRead_in  = 1'b0;
    MemWrite_in = 1'b0;
    Size_in     = 2'b10;
    Unsigned_in = 1'b0;
    RegWrite_in = 1'b0;
    MemtoReg_in = 1'b0;
  endtask

  task automatic set_load(input logic [31:0] ad, input logic [1:0] sz,
                          input logic u);
    MemRead_in  = 1'b1;
    MemWrite_in = 1'b0;
    Size_in     = sz;
    Unsigned_in = u;
    ALUData_in  = ad;
    RegWrite_in = 1'b1;
    MemtoReg_in = 1'b1;
  endtask

  task automatic quick_load(input logic [31:0] ad, input logic [1:0] sz,
                            input logic u, input logic [31:0] rd);
    @(negedge clk);
    set_load(ad, sz, u);
    @(negedge clk);
    mem_ack   = 1'b1;
    mem_rdata = rd;
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    set_nop();
    ALUData_in    = 32'h0;
    StoreData_in  = 32'h0;
    WBregister_in = 5'd7;
    mem_ack       = 1'b0;
    mem_rdata     = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_req", mem_req, 1'b0);
    chk("rst_stall", stall, 1'b0);
    chk("rst_be", mem_be, 4'b0000);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_data", MemData_out, 32'h0);
    chk("rst_buserr", bus_err, 1'b0);

    @(negedge clk);
    set_load(32'h104, 2'b10, 1'b0);
    #1;
    chk("lw_idle_rw", RegWrite_out, 1'b0);
    stall_cnt = stall ? 1 : 0;
    step();
    chk("lw_addr", mem_addr, 32'h104);
    chk("lw_be", mem_be, 4'b1111);
    chk("lw_we", mem_we, 1'b0);
    chk("lw_req", mem_req, 1'b1);
    if (stall) stall_cnt++;
    step();
    if (stall) stall_cnt++;
    @(negedge clk);
    mem_ack   = 1'b1;
    mem_rdata = 32'h8899AABB;
    #1;
    if (stall) stall_cnt++;
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    chk("lw_stall_cycles", stall_cnt, 4);
    chk("lw_done_stall", stall, 1'b0);
    chk("lw_done_data", MemData_out, 32'h8899AABB);
    chk("lw_done_rw", RegWrite_out, 1'b1);
    chk("lw_done_req", mem_req, 1'b0);
    set_nop();

    quick_load(32'h103, 2'b00, 1'b0, 32'h80112233);
    chk("lb_data", MemData_out, 32'hFFFFFF80);
    set_nop();
    quick_load(32'h103, 2'b00, 1'b1, 32'h80112233);
    chk("lbu_data", MemData_out, 32'h00000080);
    set_nop();
    quick_load(32'h102, 2'b01, 1'b0, 32'h80112233);
    chk("lh_data", MemData_out, 32'hFFFF8011);
    set_nop();
    quick_load(32'h101, 2'b00, 1'b0, 32'h80112233);
    chk("lb1_data", MemData_out, 32'h00000022);
    set_nop();

    @(negedge clk);
    MemWrite_in  = 1'b1;
    Size_in      = 2'b01;
    ALUData_in   = 32'h102;
    StoreData_in = 32'h0000ABCD;
    RegWrite_in  = 1'b1;
    #1;
    chk("sh_idle_rw", RegWrite_out, 1'b0);
    chk("sh_idle_stall", stall, 1'b1);
    step();
    chk("sh_addr", mem_addr, 32'h100);
    chk("sh_be", mem_be, 4'b1100);
    chk("sh_wdata", mem_wdata, 32'hABCDABCD);
    chk("sh_we", mem_we, 1'b1);
    chk("sh_busy_rw", RegWrite_out, 1'b0);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    chk("sh_done_stall", stall, 1'b0);
    set_nop();

    @(negedge clk);
    MemWrite_in  = 1'b1;
    Size_in      = 2'b00;
    ALUData_in   = 32'h101;
    StoreData_in = 32'h123456EF;
    step();
    chk("sb_be", mem_be, 4'b0010);
    chk("sb_wdata", mem_wdata, 32'hEFEFEFEF);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    set_nop();

    @(negedge clk);
    set_load(32'h102, 2'b10, 1'b0);
    #1;
    chk("mis_pulse", misalign, 1'b1);
    chk("mis_stall", stall, 1'b0);
    chk("mis_rw", RegWrite_out, 1'b0);
    @(negedge clk);
    set_nop();
    RegWrite_in = 1'b1;
    ALUData_in  = 32'h55;
    #1;
    chk("mis_clear", misalign, 1'b0);
    chk("mis_noreq", mem_req, 1'b0);
    chk("add_rw", RegWrite_out, 1'b1);
    chk("add_alu", ALUData_out, 32'h55);
    chk("add_wb", WBregister_out, 5'd7);

    @(negedge clk);
    set_load(32'h200, 2'b10, 1'b0);
    req_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (!stall) break;
      if (mem_req) req_cnt++;
    end
    chk("to_req_cycles", req_cnt, 8);
    chk("to_stall", stall, 1'b0);
    chk("to_buserr", bus_err, 1'b1);
    chk("to_rw", RegWrite_out, 1'b0);
    @(negedge clk);
    set_nop();
    #1;
    chk("to_buserr_clr", bus_err, 1'b0);
    chk("to_idle_stall", stall, 1'b0);

    @(negedge clk);
    set_load(32'h300, 2'b10, 1'b0);
    step();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    set_nop();
    mem_ack   = 1'b1;
    mem_rdata = 32'hDEADBEEF;
    #1;
    chk("rst2_req", mem_req, 1'b0);
    chk("rst2_stall", stall, 1'b0);
    chk("rst2_data", MemData_out, 32'h0);
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    chk("rst2_ack_req", mem_req, 1'b0);
    chk("rst2_ack_data", MemData_out, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage data-memory access unit of the 5-stage pipeline.
- Sits between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Drives a req/ack data-memory bus and performs byte/halfword/word alignment, byte enables and load sign/zero extension.
- Stalls the upstream pipeline while an access is outstanding and presents a bubble or the completed result to MEM/WB.

Parameters:
- TIMEOUT, 16, max BUSY cycles waiting for mem_ack before aborting with bus_err (>=1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- MemRead_in  in  1  load instruction in MEM.
- MemWrite_in  in  1  store instruction in MEM.
- Size_in  in  2  00 byte, 01 half, 10 word; 11 is treated as word.
- Unsigned_in  in  1  1 = zero-extend load, 0 = sign-extend.
- ALUData_in  in  32  effective address, or ALU result for non-memory instructions.
- StoreData_in  in  32  rt value for stores.
- RegWrite_in  in  1  WB control from EX/MEM.
- MemtoReg_in  in  1  WB control from EX/MEM.
- WBregister_in  in  5  destination register.
- mem_ack  in  1  memory completion, single-cycle pulse.
- mem_rdata  in  32  read data, valid with mem_ack.
- RegWrite_out  out  1  to MEM/WB (combinational).
- MemtoReg_out  out  1  to MEM/WB (combinational).
- MemData_out  out  32  aligned, extended load data (combinational from the latched word).
- ALUData_out  out  32  pass-through of ALUData_in.
- WBregister_out  out  5  pass-through of WBregister_in.
- stall  out  1  freezes PC, IF/ID, ID/EX and EX/MEM.
- mem_req  out  1  registered request, held high for the whole access.
- mem_we  out  1  registered write enable.
- mem_addr  out  32  registered word address, {addr[31:2],2'b00}.
- mem_wdata  out  32  registered store data, replicated across lanes.
- mem_be  out  4  registered byte enables, little-endian.
- misalign  out  1  1-cycle pulse: misaligned access detected.
- bus_err  out  1  1-cycle pulse: access timed out.

Behaviour:
- Reset (sync, rst=1 at a clk edge):
  - state=IDLE.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0.
  - Latched read word=0, timeout counter=0, error flag=0.
  - Hence stall=0, bus_err=0 and MemData_out=0 after reset.
  - rst overrides any in-flight access: mem_req drops at that edge and a late mem_ack is ignored.
- access = (MemRead_in|MemWrite_in) & aligned.
  - MemWrite_in has priority if both are set.
- Alignment:
  - half requires addr[0]=0; word requires addr[1:0]=00; byte is always aligned.
  - Misaligned, in IDLE: misalign=1 that cycle, no request, stall=0, RegWrite_out=0.
- Byte enables and write data:
  - byte: mem_be = 1<<addr[1:0], mem_wdata = {4{data[7:0]}}.
  - half: mem_be = addr[1] ? 1100 : 0011, mem_wdata = {2{data[15:0]}}.
  - word: mem_be = 1111, mem_wdata = data.
  - Reads use the same be encoding.
- Load extract from the latched word:
  - byte lane = addr[1:0]; half lane = addr[1].
  - Extend with sign, or zero if Unsigned_in.
- FSM:
  - IDLE:
    - access=1: stall=1, RegWrite_out=0 (bubble). On the clock edge, latch mem_* registers, clear the counter, go to BUSY.
    - access=0: stall=0, pass through RegWrite_in and MemtoReg_in.
  - BUSY:
    - mem_req=1, stall=1, RegWrite_out=0, counter increments each cycle.
    - On mem_ack: latch mem_rdata (loads only), drop mem_req, go to DONE.
    - If the counter reaches TIMEOUT-1 without mem_ack: drop mem_req, set the error flag, go to DONE.
  - DONE:
    - stall=0, mem_req=0.
    - RegWrite_out = RegWrite_in & ~error flag.
    - bus_err = error flag.
    - MemData_out is the extracted load data.
    - Next edge: go to IDLE and clear the error flag.
- EX/MEM inputs are stable throughout IDLE-access, BUSY and DONE because stall holds them. The unit relies on this.
- Minimum access latency is 3 cycles (IDLE, BUSY with ack, DONE).
- ack arriving in the first BUSY cycle is legal.
- mem_ack outside BUSY is ignored.
- MemtoReg_out = MemtoReg_in whenever RegWrite_out can be 1.
- ALUData_out and WBregister_out are always pass-through.

Test Plan:
1. lw addr 0x104, mem_ack in 3rd BUSY cycle with rdata 0x8899AABB -> mem_addr=0x104, mem_be=1111, mem_we=0; stall high 4 cycles; DONE cycle: MemData_out=0x8899AABB, RegWrite_out=1, stall=0.
2. lb addr 0x103, rdata 0x80112233 -> MemData_out=0xFFFFFF80. Repeat with Unsigned_in=1 (lbu) -> 0x00000080. lh addr 0x102, same rdata -> 0xFFFF8011.
3. sh addr 0x102, StoreData 0x0000ABCD -> mem_addr=0x100, mem_be=1100, mem_wdata=0xABCDABCD, mem_we=1; RegWrite_out=0 during stall.
4. lw addr 0x102 -> misalign pulse one cycle, mem_req never asserted, stall=0, RegWrite_out=0. Next instruction (add) passes with RegWrite_out=1.
5. TIMEOUT=8, lw with no mem_ack -> mem_req high exactly 8 cycles; DONE: bus_err=1, RegWrite_out=0; back to IDLE next cycle.
6. rst asserted in 2nd BUSY cycle, mem_ack in the following cycle -> mem_req=0, stall=0 after the edge; ack ignored; MemData_out=0.
